lut_sweep_eval: RTL
===================

Name: lut_sweep_eval

Overview:
Parametrised N-input programmable boolean function unit. A loadable truth-table register replaces fixed gate logic. The block drives a registered output F and its complement Fn.
- Direct mode: evaluates an externally applied input vector.
- Sweep mode: self-steps through all 2^N input combinations with a programmable dwell per vector and counts the minterms where F=1.
- Used as the reusable function-evaluation/self-check block for lab designs.

Parameters:
N_IN, 3, number of function inputs (1..6)
DWELL, 4, clock cycles each vector is held in sweep mode (>=2)
TT_RST, 0, truth-table reset value, width 2^N_IN

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
tt_load  in  1  write tt_data into truth table
tt_data  in  2^N_IN  truth table; bit i = F for input vector i
mode  in  1  0=direct, 1=sweep
in_vec  in  N_IN  direct-mode input vector
start  in  1  begin sweep (IDLE and mode=1 only)
f  out  1  registered function output
fn  out  1  registered complement, always ~f
cur_vec  out  N_IN  vector currently being evaluated in sweep
busy  out  1  high in RUN
valid  out  1  one-cycle pulse: f is final for cur_vec
done  out  1  one-cycle pulse at sweep end
ones_cnt  out  N_IN+1  count of vectors with F=1 in last sweep

Behaviour:
- Reset (async, rst_n=0):
  - tt=TT_RST, state=IDLE.
  - f=0, fn=1, cur_vec=0, busy=0, valid=0, done=0, ones_cnt=0, dwell_cnt=0.
- Evaluation, every cycle:
  - sel = (state==RUN) ? cur_vec : in_vec.
  - f <= tt[sel]; fn <= ~tt[sel].
  - Latency is 1 cycle from sel to f.
- Truth-table load:
  - tt_load=1 in IDLE or DONE: tt <= tt_data at that edge.
  - tt_load in RUN is ignored.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - start=1 and mode=1 -> RUN, with cur_vec=0, dwell_cnt=0, ones_cnt=0.
  - start with mode=0 is ignored.
- RUN:
  - busy=1; dwell_cnt increments each cycle.
  - When dwell_cnt==DWELL-1: valid=1 that cycle, and ones_cnt += tt[cur_vec] at the edge.
  - At that same edge, if cur_vec==2^N_IN-1 -> DONE; otherwise cur_vec++ and dwell_cnt=0.
- DONE:
  - done=1 for one cycle, busy=0, then -> IDLE.
  - cur_vec and ones_cnt hold until the next start.
- Sweep duration: exactly 2^N_IN*DWELL cycles in RUN.
- ignored inputs: start and mode changes during RUN are ignored; mode is sampled only at start.
- Same-edge tt_load+start in IDLE: both take effect; the sweep uses the newly loaded table.
- Width rules:
  - ones_cnt is N_IN+1 bits, so the all-ones table gives 2^N_IN with no wrap.
  - cur_vec increment never wraps within a sweep.
- rst_n low mid-sweep: immediate return to reset values, with no done pulse.

Decomposition:
- Package lut_sweep_pkg:
  - state enum (IDLE, RUN, DONE)
  - localparams TT_W=2^N_IN, CNT_W=N_IN+1
  - dwell counter width $clog2(DWELL)
- Sub-module lut_core:
  - holds the truth-table register, load gating, select mux and registered f/fn.
  - the top level holds the FSM, counters and ones_cnt.

Test Plan:
1. Reset: assert rst_n=0 mid-cycle -> immediately f=0, fn=1, busy=0, valid=0, done=0, ones_cnt=0, cur_vec=0.
2. Direct mode, table 8'b0011_1010:
   - load the table, mode=0, in_vec=3'b011 -> next cycle f=1, fn=0.
   - in_vec=3'b110 -> f=0, fn=1.
   - in_vec=3'b100 -> f=1.
3. Sweep, same table, DWELL=4:
   - pulse start -> busy for 32 cycles with 8 valid pulses.
   - f at the valid pulses reads 0,1,0,1,1,1,0,0.
   - done pulses the cycle after RUN ends; ones_cnt=4.
4. Illegal actions in RUN:
   - tt_load=1 with tt_data=8'hFF during RUN -> ignored; ones_cnt still 4.
   - start pulses during RUN -> no restart; cur_vec keeps incrementing monotonically.
5. Reset mid-sweep: rst_n=0 while cur_vec=5 -> state IDLE, ones_cnt=0, no done pulse; a subsequent start sweeps from cur_vec=0.
6. Wide case: N_IN=4, DWELL=2, table 16'hFFFF -> sweep lasts 32 cycles; ones_cnt=5'd16, no wrap.

Source files
------------

// File: rtl/lut_sweep_pkg.sv
// Shared types and width helpers for the programmable LUT function unit.
package lut_sweep_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } state_e;

  // Widths for the default 3-input configuration; instances derive their own below.
  localparam int unsigned TT_W  = 8;
  localparam int unsigned CNT_W = 4;

  function automatic int unsigned tt_width(input int unsigned n_in);
    return 32'd1 << n_in;
  endfunction

  function automatic int unsigned cnt_width(input int unsigned n_in);
    return n_in + 1;
  endfunction

  function automatic int unsigned dwell_width(input int unsigned dwell);
    return (dwell > 1) ? $clog2(dwell) : 1;
  endfunction

endpackage

// File: rtl/lut_sweep_eval_if.sv
// Control/result bundle between a driver and the LUT sweep evaluator.
interface lut_sweep_eval_if #(
  parameter int unsigned N_IN = 3
);

  logic [(2**N_IN)-1:0] tt_data;
  logic                 tt_load;
  logic                 mode;
  logic [N_IN-1:0]      in_vec;
  logic                 start;
  logic                 f;
  logic                 fn;
  logic [N_IN-1:0]      cur_vec;
  logic                 busy;
  logic                 valid;
  logic                 done;
  logic [N_IN:0]        ones_cnt;

  modport master (
    output tt_load, tt_data, mode, in_vec, start,
    input  f, fn, cur_vec, busy, valid, done, ones_cnt
  );

  modport slave (
    input  tt_load, tt_data, mode, in_vec, start,
    output f, fn, cur_vec, busy, valid, done, ones_cnt
  );

endinterface

// File: rtl/lut_core.sv
// Truth-table register, load gating, input select and registered f/fn.
module lut_core #(
  parameter int unsigned     N_IN   = 3,
  parameter int unsigned     TT_W   = 8,
  parameter logic [TT_W-1:0] TT_RST = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            tt_load,
  input  logic [TT_W-1:0] tt_data,
  input  logic            run,
  input  logic [N_IN-1:0] cur_vec,
  input  logic [N_IN-1:0] in_vec,
  output logic            tt_bit,
  output logic            f,
  output logic            fn
);

  logic [TT_W-1:0] tt_q;
  logic [N_IN-1:0] sel;

  assign sel    = run ? cur_vec : in_vec;
  assign tt_bit = tt_q[sel];

  // The table is frozen while a sweep is running.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tt_q <= TT_RST;
    end else if (tt_load && !run) begin
      tt_q <= tt_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      f  <= 1'b0;
      fn <= 1'b1;
    end else begin
      f  <= tt_bit;
      fn <= ~tt_bit;
    end
  end

endmodule

// File: rtl/lut_sweep_eval.sv
// Programmable N-input boolean unit with direct evaluation and a self-stepping minterm sweep.
module lut_sweep_eval
  import lut_sweep_pkg::*;
#(
  parameter int unsigned             N_IN   = 3,
  parameter int unsigned             DWELL  = 4,
  parameter logic [(2**N_IN)-1:0]    TT_RST = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  lut_sweep_eval_if.slave   bus
);

  localparam int unsigned TT_LEN = tt_width(N_IN);
  localparam int unsigned CNT_LEN = cnt_width(N_IN);
  localparam int unsigned DW_LEN = dwell_width(DWELL);
  localparam logic [DW_LEN-1:0] DWELL_LAST = DW_LEN'(DWELL - 1);
  localparam logic [N_IN-1:0] VEC_LAST = {N_IN{1'b1}};

  state_e              state_q;
  logic [N_IN-1:0]     cur_vec_q;
  logic [DW_LEN-1:0]   dwell_q;
  logic [CNT_LEN-1:0]  ones_q;
  logic                run;
  logic                tt_bit;
  logic                f;
  logic                fn;

  assign run = (state_q == StRun);

  lut_core #(
    .N_IN   (N_IN),
    .TT_W   (TT_LEN),
    .TT_RST (TT_RST)
  ) u_core (
    .clk     (clk),
    .rst_n   (rst_n),
    .tt_load (bus.tt_load),
    .tt_data (bus.tt_data),
    .run     (run),
    .cur_vec (cur_vec_q),
    .in_vec  (bus.in_vec),
    .tt_bit  (tt_bit),
    .f       (f),
    .fn      (fn)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      cur_vec_q <= '0;
      dwell_q   <= '0;
      ones_q    <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          // mode is only looked at here; later changes cannot affect a running sweep
          if (bus.start && bus.mode) begin
            state_q   <= StRun;
            cur_vec_q <= '0;
            dwell_q   <= '0;
            ones_q    <= '0;
          end
        end
        StRun: begin
          if (dwell_q == DWELL_LAST) begin
            ones_q <= ones_q + CNT_LEN'(tt_bit);
            if (cur_vec_q == VEC_LAST) begin
              state_q <= StDone;
            end else begin
              cur_vec_q <= cur_vec_q + 1'b1;
              dwell_q   <= '0;
            end
          end else begin
            dwell_q <= dwell_q + 1'b1;
          end
        end
        StDone: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign bus.f        = f;
  assign bus.fn       = fn;
  assign bus.cur_vec  = cur_vec_q;
  assign bus.busy     = run;
  assign bus.valid    = run && (dwell_q == DWELL_LAST);
  assign bus.done     = (state_q == StDone);
  assign bus.ones_cnt = ones_q;

endmodule
